x_pcie_tx_skp_insert: RTL and testbench

- Transmit-side clock tolerance compensation for one PCIe lane. The receive-side CTC FIFO in the far-end receiver depends on this block.
- Schedules SKP ordered sets (COM 0xBC, followed by SKP_LEN × SKP 0x1C, all K-symbols) at a fixed symbol interval.
- Inserts them into the 8-bit transmit symbol stream only at packet/ordered-set boundaries, stalling the upstream link layer while inserting.
- Sits between the TX data mux and the PCS/SERDES TX interface, one symbol per clock.

---
 rtl/x_pcie_tx_skp_insert.sv | 258 +++++++++++++++++++++++++
 tb/tb_x_pcie_tx_skp_insert.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_pcie_tx_skp_insert.sv
// -----------------------------------------------------------------------------
// x_pcie_tx_skp_insert
//
// Transmit-side clock tolerance compensation for one PCIe lane. A free-running
// interval counter schedules SKP ordered sets (COM 0xBC followed by SKP_LEN
// SKP 0x1C symbols, all K-symbols). Scheduled sets are queued in a small
// pending counter and inserted into the 8-bit symbol stream only where the
// upstream marks a packet/ordered-set boundary (or the stream is idle). While
// a set is being inserted, the upstream link layer is stalled via in_ready.
// The far-end receiver CTC FIFO relies on these sets arriving on time.
//
// Ports:
//   clk           symbol clock, one symbol per cycle
//   rst           asynchronous active-high reset
//   skp_disable   suppresses SKP scheduling and insertion
//   skp_force     one-cycle pulse requesting one extra SKP ordered set
//   in_valid      upstream symbol valid
//   in_data[7:0]  upstream symbol
//   in_kcntl      upstream K-control flag
//   in_boundary   upstream symbol starts a TLP/DLLP/ordered set
//   in_ready      upstream symbol accepted this cycle (combinational)
//   out_data[7:0] transmit symbol (registered)
//   out_kcntl     transmit K flag (registered)
//   skp_sent      pulse aligned with the last SKP symbol of a set
//   pend_count    number of ordered sets waiting to be inserted
//   pend_overflow pulse when a request is dropped at saturation
// -----------------------------------------------------------------------------
module x_pcie_tx_skp_insert #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3,
  parameter int MAX_PEND     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       skp_disable,
  input  logic       skp_force,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_kcntl,
  input  logic       in_boundary,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_kcntl,
  output logic       skp_sent,
  output logic [1:0] pend_count,
  output logic       pend_overflow
);

  localparam logic [7:0]  SYM_COM   = 8'hBC;
  localparam logic [7:0]  SYM_SKP   = 8'h1C;
  localparam logic [7:0]  SYM_IDLE  = 8'h00;
  localparam logic [10:0] INTV_LAST = 11'(SKP_INTERVAL - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(SKP_LEN - 1);
  localparam logic [2:0]  PEND_MAX  = 3'(MAX_PEND);

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_COM  = 2'd1,
    ST_SKP  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [10:0] intv_r;
  logic [10:0] intv_nxt_s;
  logic        tick_s;
  logic [2:0]  idx_r;
  logic [2:0]  idx_nxt_s;
  logic [1:0]  pend_r;
  logic [1:0]  pend_nxt_s;
  logic [2:0]  pend_sum_s;
  logic [2:0]  pend_net_s;
  logic        ovf_nxt_s;
  logic        set_done_s;
  logic        start_ins_s;
  logic [7:0]  data_nxt_s;
  logic        k_nxt_s;
  logic        sent_nxt_s;
  logic [7:0]  out_data_r;
  logic        out_kcntl_r;
  logic        skp_sent_r;
  logic        pend_ovf_r;

  // Interval counter: wraps at SKP_INTERVAL-1 and emits the scheduling tick.
  always_comb begin
    intv_nxt_s = intv_r;
    tick_s     = 1'b0;
    if (skp_disable) begin
      intv_nxt_s = 11'd0;
    end else if (intv_r == INTV_LAST) begin
      intv_nxt_s = 11'd0;
      tick_s     = 1'b1;
    end else begin
      intv_nxt_s = intv_r + 11'd1;
    end
  end

  // Last SKP symbol of the current set is being emitted this cycle.
  assign set_done_s = (state_r == ST_SKP) && (idx_r == IDX_LAST);

  // Pending counter: net of tick, force and completion, saturating at MAX_PEND.
  always_comb begin
    pend_sum_s = {1'b0, pend_r} + {2'b00, tick_s} + {2'b00, skp_force};
    pend_net_s = pend_sum_s;
    pend_nxt_s = pend_r;
    ovf_nxt_s  = 1'b0;
    if (set_done_s && (pend_sum_s != 3'd0)) begin
      pend_net_s = pend_sum_s - 3'd1;
    end else begin
      pend_net_s = pend_sum_s;
    end
    // Disabling only discards the backlog once no set is in flight.
    if (skp_disable && (state_r == ST_PASS)) begin
      pend_nxt_s = 2'd0;
      ovf_nxt_s  = 1'b0;
    end else if (pend_net_s > PEND_MAX) begin
      pend_nxt_s = PEND_MAX[1:0];
      ovf_nxt_s  = 1'b1;
    end else begin
      pend_nxt_s = pend_net_s[1:0];
      ovf_nxt_s  = 1'b0;
    end
  end

  // Insertion may start only at a boundary symbol or when upstream is idle.
  assign start_ins_s = (state_r == ST_PASS) && (pend_r != 2'd0) && !skp_disable &&
                       (!in_valid || in_boundary);
  assign in_ready    = (state_r == ST_PASS) && !start_ins_s;

  // Next-state and next-symbol selection. The COM symbol is registered on the
  // PASS decision, so PASS jumps straight to SKP; the COM state is only used
  // for back-to-back sets.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    data_nxt_s  = SYM_IDLE;
    k_nxt_s     = 1'b0;
    sent_nxt_s  = 1'b0;
    case (state_r)
      ST_PASS: begin
        if (start_ins_s) begin
          data_nxt_s  = SYM_COM;
          k_nxt_s     = 1'b1;
          state_nxt_s = ST_SKP;
          idx_nxt_s   = 3'd0;
        end else if (in_valid) begin
          data_nxt_s = in_data;
          k_nxt_s    = in_kcntl;
        end else begin
          data_nxt_s = SYM_IDLE;
          k_nxt_s    = 1'b0;
        end
      end
      ST_COM: begin
        data_nxt_s  = SYM_COM;
        k_nxt_s     = 1'b1;
        state_nxt_s = ST_SKP;
        idx_nxt_s   = 3'd0;
      end
      ST_SKP: begin
        data_nxt_s = SYM_SKP;
        k_nxt_s    = 1'b1;
        if (idx_r == IDX_LAST) begin
          sent_nxt_s = 1'b1;
          idx_nxt_s  = 3'd0;
          // Chain the next set without a gap if work remains.
          if ((pend_nxt_s != 2'd0) && !skp_disable) begin
            state_nxt_s = ST_COM;
          end else begin
            state_nxt_s = ST_PASS;
          end
        end else begin
          idx_nxt_s = idx_r + 3'd1;
        end
      end
      default: begin
        state_nxt_s = ST_PASS;
        idx_nxt_s   = 3'd0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_PASS;
      intv_r      <= 11'd0;
      idx_r       <= 3'd0;
      pend_r      <= 2'd0;
      out_data_r  <= 8'h00;
      out_kcntl_r <= 1'b0;
      skp_sent_r  <= 1'b0;
      pend_ovf_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      intv_r      <= intv_nxt_s;
      idx_r       <= idx_nxt_s;
      pend_r      <= pend_nxt_s;
      out_data_r  <= data_nxt_s;
      out_kcntl_r <= k_nxt_s;
      skp_sent_r  <= sent_nxt_s;
      pend_ovf_r  <= ovf_nxt_s;
    end
  end

  assign out_data      = out_data_r;
  assign out_kcntl     = out_kcntl_r;
  assign skp_sent      = skp_sent_r;
  assign pend_count    = pend_r;
  assign pend_overflow = pend_ovf_r;

  x_pcie_tx_skp_insert_chk #(
    .MAX_PEND (MAX_PEND)
  ) u_chk (
    .clk           (clk),
    .rst           (rst),
    .out_data      (out_data_r),
    .out_kcntl     (out_kcntl_r),
    .skp_sent      (skp_sent_r),
    .pend_count    (pend_r),
    .pend_overflow (pend_ovf_r)
  );

endmodule

// -----------------------------------------------------------------------------
// x_pcie_tx_skp_insert_chk
//
// Property checker for the SKP inserter outputs.
// Ports: clk, rst, and the registered outputs of the inserter.
// -----------------------------------------------------------------------------
module x_pcie_tx_skp_insert_chk #(
  parameter int MAX_PEND = 3
) (
  input logic       clk,
  input logic       rst,
  input logic [7:0] out_data,
  input logic       out_kcntl,
  input logic       skp_sent,
  input logic [1:0] pend_count,
  input logic       pend_overflow
);

  localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);

  // Completion pulse always accompanies a SKP K-symbol on the wire.
  a_sent_on_skp: assert property (@(posedge clk) disable iff (rst)
    skp_sent |-> (out_kcntl && (out_data == 8'h1C)));

  // Pending count never exceeds its saturation limit.
  a_pend_bound: assert property (@(posedge clk) disable iff (rst)
    pend_count <= PEND_MAX);

  // A dropped request can only happen with the counter saturated.
  a_ovf_sat: assert property (@(posedge clk) disable iff (rst)
    pend_overflow |-> (pend_count == PEND_MAX));

endmodule

// File: tb/tb_x_pcie_tx_skp_insert.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for x_pcie_tx_skp_insert (interval 16, 3 SKPs,
// pending limit 3). After each reset release the edges are numbered from 1;
// the interval counter reads n mod 16 after edge n, so pending increments land
// on edges 16, 32, 48, ...
// -----------------------------------------------------------------------------
module tb_x_pcie_tx_skp_insert;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       skp_disable;
  logic       skp_force;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_kcntl;
  logic       in_boundary;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_kcntl;
  logic       skp_sent;
  logic [1:0] pend_count;
  logic       pend_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  x_pcie_tx_skp_insert #(
    .SKP_INTERVAL (16),
    .SKP_LEN      (3),
    .MAX_PEND     (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .skp_disable   (skp_disable),
    .skp_force     (skp_force),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_kcntl      (in_kcntl),
    .in_boundary   (in_boundary),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_kcntl     (out_kcntl),
    .skp_sent      (skp_sent),
    .pend_count    (pend_count),
    .pend_overflow (pend_overflow)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid    = 1'b0;
    in_data     = 8'h00;
    in_kcntl    = 1'b0;
    in_boundary = 1'b0;
    skp_force   = 1'b0;
    skp_disable = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Output symbol as {K, data}.
  function automatic int outv();
    return int'({out_kcntl, out_data});
  endfunction

  // Expected {K, data} at position pos inside a run of ordered sets.
  function automatic int os_sym(input int pos);
    return ((pos % 4) == 0) ? 32'h1BC : 32'h11C;
  endfunction

  initial begin
    int exp;
    int cnt;
    int rx;
    int idx;
    int sets;
    int d;
    logic acc;
    logic prev_skp;
    logic found;

    // ---------------- reset values ----------------
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_data", 32'(out_data), 0);
    check_eq("rst_k", 32'(out_kcntl), 0);
    check_eq("rst_sent", 32'(skp_sent), 0);
    check_eq("rst_pend", 32'(pend_count), 0);
    check_eq("rst_ovf", 32'(pend_overflow), 0);
    check_eq("rst_ready", 32'(in_ready), 1);
    rst = 1'b0;

    // ---------------- free run, idle upstream ----------------
    for (int n = 1; n <= 36; n++) begin
      step();
      exp = 32'h000;
      if (n == 17 || n == 33) exp = 32'h1BC;
      else if ((n >= 18 && n <= 20) || (n >= 34 && n <= 36)) exp = 32'h11C;
      check_eq("free_sym", outv(), exp);
      check_eq("free_sent", 32'(skp_sent), 32'(n == 20 || n == 36));
      if (n == 16) check_eq("free_pend", 32'(pend_count), 1);
    end

    // ---------------- no boundary, then two back-to-back sets ----------------
    do_reset();
    in_valid = 1'b1;
    for (int n = 1; n <= 36; n++) begin
      step();
      check_eq("fwd_sym", outv(), n - 1);
      in_data = 8'(n);
    end
    check_eq("fwd_pend2", 32'(pend_count), 2);
    in_boundary = 1'b1;
    @(negedge clk);
    check_eq("hold_ready", 32'(in_ready), 0);
    for (int n = 37; n <= 45; n++) begin
      step();
      exp = (n <= 44) ? os_sym(n - 37) : 36;
      check_eq("b2b_sym", outv(), exp);
      check_eq("b2b_sent", 32'(skp_sent), 32'(n == 40 || n == 44));
      if (n <= 44) begin
        @(negedge clk);
        check_eq("b2b_ready", 32'(in_ready), 32'(n == 44));
      end
    end
    check_eq("b2b_pend0", 32'(pend_count), 0);
    drive_idle();

    // ---------------- ramp with boundary every 8th symbol ----------------
    do_reset();
    idx = 0;
    rx = 0;
    sets = 0;
    prev_skp = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h01;
    in_boundary = 1'b1;
    for (int c = 0; c < 400 && rx < 64; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (skp_sent) sets++;
      if (!out_kcntl && out_data != 8'h00) begin
        check_eq("ramp_data", 32'(out_data), rx + 1);
        if (prev_skp) begin
          d = int'(out_data) - 1;
          check_eq("ramp_bnd", d % 8, 0);
        end
        rx++;
      end
      prev_skp = out_kcntl && (out_data == 8'h1C);
      if (acc) idx++;
      in_valid    = (idx < 64);
      in_data     = 8'(idx + 1);
      in_boundary = ((idx % 8) == 0);
    end
    check_eq("ramp_cnt", rx, 64);
    check_eq("ramp_sets", 32'(sets >= 3), 1);
    drive_idle();

    // ---------------- saturation ----------------
    do_reset();
    in_valid = 1'b1;
    cnt = 0;
    for (int n = 1; n <= 66; n++) begin
      step();
      if (pend_overflow) cnt++;
      if (n == 48) check_eq("sat_pend48", 32'(pend_count), 3);
      if (n == 64) begin
        check_eq("sat_ovf64", 32'(pend_overflow), 1);
        check_eq("sat_pend64", 32'(pend_count), 3);
      end
      in_data = 8'(n);
    end
    check_eq("sat_ovf_cnt", cnt, 1);
    in_boundary = 1'b1;
    cnt = 0;
    for (int n = 67; n <= 79; n++) begin
      step();
      exp = (n <= 78) ? os_sym(n - 67) : 66;
      check_eq("sat_sym", outv(), exp);
      if (skp_sent) cnt++;
    end
    check_eq("sat_sets", cnt, 3);
    check_eq("sat_pend0", 32'(pend_count), 0);
    drive_idle();

    // ---------------- skp_force with tick, and at saturation ----------------
    do_reset();
    in_valid = 1'b1;
    for (int n = 1; n <= 31; n++) begin
      step();
      if (n == 16) check_eq("frc_pend1", 32'(pend_count), 1);
    end
    skp_force = 1'b1;
    step();
    check_eq("frc_pend3", 32'(pend_count), 3);
    check_eq("frc_noovf", 32'(pend_overflow), 0);
    step();
    check_eq("frc_satpend", 32'(pend_count), 3);
    check_eq("frc_ovf", 32'(pend_overflow), 1);
    skp_force = 1'b0;
    step();
    check_eq("frc_ovf_end", 32'(pend_overflow), 0);
    drive_idle();

    // ---------------- skp_disable mid-set, then rst mid-set ----------------
    do_reset();
    for (int n = 1; n <= 17; n++) step();
    check_eq("dis_com", outv(), 32'h1BC);
    skp_force = 1'b1;
    step();
    check_eq("dis_skp1", outv(), 32'h11C);
    check_eq("dis_pend2", 32'(pend_count), 2);
    skp_force = 1'b0;
    step();
    check_eq("dis_skp2", outv(), 32'h11C);
    skp_disable = 1'b1;
    step();
    check_eq("dis_skp3", outv(), 32'h11C);
    check_eq("dis_sent", 32'(skp_sent), 1);
    check_eq("dis_pend1", 32'(pend_count), 1);
    step();
    check_eq("dis_idle", outv(), 32'h000);
    check_eq("dis_pend0", 32'(pend_count), 0);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (out_kcntl) cnt++;
    end
    check_eq("dis_no_k", cnt, 0);
    check_eq("dis_pend_hold", 32'(pend_count), 0);

    skp_disable = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (outv() == 32'h1BC) found = 1'b1;
    end
    check_eq("rst_wait_com", 32'(found), 1);
    step();
    check_eq("rst_pre_skp", outv(), 32'h11C);
    rst = 1'b1;
    #1;
    check_eq("rst_abort_sym", outv(), 32'h000);
    check_eq("rst_abort_pend", 32'(pend_count), 0);
    rst = 1'b0;
    step();
    check_eq("rst_post_sym", outv(), 32'h000);
    check_eq("rst_post_ready", 32'(in_ready), 1);
    cnt = 0;
    for (int n = 0; n < 3; n++) begin
      step();
      if (out_kcntl) cnt++;
    end
    check_eq("rst_post_no_k", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
